// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state type, table selectors and default parameters for the fetch unit
package fetch_unit_pkg;
   localparam int PC_W_DEF      = 16;
   localparam int LUT_IDX_W_DEF = 5;
   localparam int RAS_DEPTH_DEF = 4;
   localparam logic LUT_SEL_REL = 1'b0;
   localparam logic LUT_SEL_ABS = 1'b1;
   typedef enum logic {RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_ras.sv
// fetch_ras: circular return-address stack; a push when full overwrites the oldest entry
module fetch_ras #(
   parameter int PC_W      = 16,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] push_data,
   output logic [PC_W-1:0] top,
   output logic            full,
   output logic            empty,
   output logic            overflow,
   output logic            underflow
);
   localparam int PW = $clog2(RAS_DEPTH);
   logic [PC_W-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]   sp, sp_dec;
   logic [PW:0]     cnt;
   assign sp_dec = sp - PW'(1);
   assign top    = mem[sp_dec];
   assign full   = cnt == (PW+1)'(RAS_DEPTH);
   assign empty  = cnt == '0;
   always_ff @(posedge clk)
      if (!rst && push && !pop) mem[sp] <= push_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         sp        <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (pop) begin
         if (empty) underflow <= 1'b1;
         else begin
            sp  <= sp_dec;
            cnt <= cnt - (PW+1)'(1);
         end
      end else if (push) begin
         sp <= sp + PW'(1);
         if (full) overflow <= 1'b1;
         else cnt <= cnt + (PW+1)'(1);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter sequencer with branch tables, call/return stack and halt
module fetch_unit import fetch_unit_pkg::*; #(
   parameter int PC_W      = PC_W_DEF,
   parameter int LUT_IDX_W = LUT_IDX_W_DEF,
   parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 branch_abs,
   input  logic                 branch_rel_z,
   input  logic                 branch_rel_nz,
   input  logic                 call,
   input  logic                 ret,
   input  logic                 halt,
   input  logic                 zero_flag,
   input  logic [LUT_IDX_W-1:0] lut_idx,
   input  logic                 lut_wr_en,
   input  logic                 lut_wr_sel,
   input  logic [PC_W-1:0]      lut_wr_data,
   output logic [PC_W-1:0]      pc,
   output logic                 done,
   output logic                 ras_overflow,
   output logic                 ras_underflow
);
   localparam int N = 2**LUT_IDX_W;
   fetch_state_t    state;
   logic [PC_W-1:0] rel_tab [N];
   logic [PC_W-1:0] abs_tab [N];
   logic [PC_W-1:0] pc_inc, pc_nxt, abs_tgt, rel_tgt, ras_top;
   logic            run, taken, push, pop, ras_empty;
   assign run     = state == RUN && !stall;
   assign pc_inc  = pc + PC_W'(1);
   assign abs_tgt = abs_tab[lut_idx];
   assign rel_tgt = pc + rel_tab[lut_idx];
   assign taken   = (branch_rel_z & zero_flag) | (branch_rel_nz & ~zero_flag);
   assign push    = run & ~halt & ~ret & call;
   assign pop     = run & ~halt & ret;
   assign done    = state == HALTED;
   always_comb
      pc_nxt = halt ? pc :
               ret ? (ras_empty ? pc_inc : ras_top) :
               (call | branch_abs) ? abs_tgt :
               taken ? rel_tgt : pc_inc;
   always_ff @(posedge CLK) begin
      if (reset) begin
         pc    <= '0;
         state <= RUN;
      end else if (run) begin
         pc <= pc_nxt;
         if (halt) state <= HALTED;
      end
   end
   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            rel_tab[i] <= '0;
            abs_tab[i] <= '0;
         end
      end else if (lut_wr_en) begin
         if (lut_wr_sel == LUT_SEL_ABS) abs_tab[lut_idx] <= lut_wr_data;
         else rel_tab[lut_idx] <= lut_wr_data;
      end
   end
   fetch_ras #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
      .clk       (CLK),
      .rst       (reset),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .top       (ras_top),
      .full      (),
      .empty     (ras_empty),
      .overflow  (ras_overflow),
      .underflow (ras_underflow)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus random traffic checked against a queue-based model
module tb_fetch_unit;
   logic        CLK = 1'b0;
   logic        reset, stall, branch_abs, branch_rel_z, branch_rel_nz, call, ret, halt, zero_flag;
   logic [4:0]  lut_idx;
   logic        lut_wr_en, lut_wr_sel;
   logic [15:0] lut_wr_data;
   logic [15:0] pc;
   logic        done, ras_overflow, ras_underflow;
   int checks = 0;
   int errors = 0;
   logic [15:0] m_pc;
   logic [15:0] m_rel [32];
   logic [15:0] m_abs [32];
   logic [15:0] m_stk [$];
   bit          m_halt, m_ovf, m_unf;
   fetch_unit dut (
      .CLK(CLK), .reset(reset), .stall(stall), .branch_abs(branch_abs),
      .branch_rel_z(branch_rel_z), .branch_rel_nz(branch_rel_nz), .call(call), .ret(ret),
      .halt(halt), .zero_flag(zero_flag), .lut_idx(lut_idx), .lut_wr_en(lut_wr_en),
      .lut_wr_sel(lut_wr_sel), .lut_wr_data(lut_wr_data), .pc(pc), .done(done),
      .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
   );
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask
   task automatic clr();
      {reset, stall, branch_abs, branch_rel_z, branch_rel_nz, call, ret, halt, zero_flag} = '0;
      lut_idx = '0; lut_wr_en = 1'b0; lut_wr_sel = 1'b0; lut_wr_data = '0;
   endtask
   task automatic tick();
      if (reset) begin
         m_pc = '0; m_halt = 0; m_ovf = 0; m_unf = 0; m_stk.delete();
         for (int i = 0; i < 32; i++) begin m_rel[i] = '0; m_abs[i] = '0; end
      end else begin
         if (!m_halt && !stall) begin
            if (halt) m_halt = 1;
            else if (ret) begin
               if (m_stk.size() == 0) begin m_unf = 1; m_pc = m_pc + 16'd1; end
               else m_pc = m_stk.pop_back();
            end else if (call) begin
               if (m_stk.size() == 4) begin void'(m_stk.pop_front()); m_ovf = 1; end
               m_stk.push_back(m_pc + 16'd1);
               m_pc = m_abs[lut_idx];
            end else if (branch_abs) m_pc = m_abs[lut_idx];
            else if ((branch_rel_z && zero_flag) || (branch_rel_nz && !zero_flag)) m_pc = m_pc + m_rel[lut_idx];
            else m_pc = m_pc + 16'd1;
         end
         if (lut_wr_en) begin
            if (lut_wr_sel) m_abs[lut_idx] = lut_wr_data;
            else m_rel[lut_idx] = lut_wr_data;
         end
      end
      @(posedge CLK); #1;
      chk("pc", pc, m_pc);
      chk("done", 16'(done), 16'(m_halt));
      chk("ovf", 16'(ras_overflow), 16'(m_ovf));
      chk("unf", 16'(ras_underflow), 16'(m_unf));
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic do_reset();
      clr(); reset = 1'b1; tick(); reset = 1'b0;
   endtask
   initial begin
      clr();
      #2;
      do_reset();
      chk("rst_pc", pc, 16'd0);
      idle(3);
      chk("idle_pc", pc, 16'd3);
      chk("idle_done", 16'(done), 16'd0);
      lut_wr_en = 1; lut_wr_sel = 0; lut_idx = 2; lut_wr_data = 16'hfffc; tick(); clr();
      idle(6);
      chk("pc10", pc, 16'd10);
      branch_rel_nz = 1; lut_idx = 2; tick();
      chk("rel_nz_taken", pc, 16'd6);
      zero_flag = 1; tick(); clr();
      chk("rel_nz_not", pc, 16'd7);
      do_reset();
      lut_wr_en = 1; lut_wr_sel = 1; lut_idx = 1; lut_wr_data = 16'd100; tick(); clr();
      idle(19);
      call = 1; lut_idx = 1; tick(); clr();
      chk("call_tgt", pc, 16'd100);
      ret = 1; tick(); clr();
      chk("ret_addr", pc, 16'd21);
      do_reset();
      for (int k = 0; k < 5; k++) begin
         lut_wr_en = 1; lut_wr_sel = 1; lut_idx = 5'(k); lut_wr_data = 16'(100 * (k + 1)); tick();
      end
      clr();
      for (int k = 0; k < 5; k++) begin call = 1; lut_idx = 5'(k); tick(); end
      clr();
      chk("nest_pc", pc, 16'd500);
      chk("nest_ovf", 16'(ras_overflow), 16'd1);
      ret = 1;
      idle(4);
      chk("ret4_pc", pc, 16'd101);
      chk("ret4_unf", 16'(ras_underflow), 16'd0);
      tick(); clr();
      chk("ret5_pc", pc, 16'd102);
      chk("ret5_unf", 16'(ras_underflow), 16'd1);
      do_reset();
      idle(30);
      halt = 1; tick(); clr();
      chk("halt_pc", pc, 16'd30);
      chk("halt_done", 16'(done), 16'd1);
      branch_abs = 1; call = 1; tick(); clr();
      chk("halted_pc", pc, 16'd30);
      do_reset();
      chk("rehalt_pc", pc, 16'd0);
      chk("rehalt_done", 16'(done), 16'd0);
      lut_wr_en = 1; lut_wr_sel = 1; lut_idx = 3; lut_wr_data = 16'd50; branch_abs = 1; tick(); clr();
      chk("rw_old", pc, 16'd0);
      branch_abs = 1; lut_idx = 3; tick(); clr();
      chk("rw_new", pc, 16'd50);
      stall = 1; branch_abs = 1; lut_wr_en = 1; lut_wr_sel = 1; lut_idx = 4; lut_wr_data = 16'd77; tick(); clr();
      chk("stall_pc", pc, 16'd50);
      branch_abs = 1; lut_idx = 4; tick(); clr();
      chk("stall_wr", pc, 16'd77);
      stall = 1; reset = 1; tick(); clr();
      chk("rst_stall", pc, 16'd0);
      lut_wr_en = 1; lut_wr_sel = 1; lut_idx = 0; lut_wr_data = 16'hffff; tick(); clr();
      branch_abs = 1; tick(); clr();
      chk("wrap_top", pc, 16'hffff);
      tick();
      chk("wrap_zero", pc, 16'd0);
      for (int n = 0; n < 600; n++) begin
         reset         = $urandom_range(0, 59) == 0;
         stall         = $urandom_range(0, 4) == 0;
         halt          = $urandom_range(0, 39) == 0;
         branch_abs    = $urandom_range(0, 5) == 0;
         branch_rel_z  = $urandom_range(0, 3) == 0;
         branch_rel_nz = $urandom_range(0, 3) == 0;
         call          = $urandom_range(0, 3) == 0;
         ret           = $urandom_range(0, 3) == 0;
         zero_flag     = 1'($urandom);
         lut_idx       = 5'($urandom_range(0, 7));
         lut_wr_en     = $urandom_range(0, 2) == 0;
         lut_wr_sel    = 1'($urandom);
         lut_wr_data   = 16'($urandom);
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 16: program counter and target width in bits.
REQ-002 Parameter LUT_IDX_W, default 5: branch-table index width; each table holds 2**LUT_IDX_W entries.
REQ-003 Parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, >=2.
REQ-004 Port CLK, input, 1: single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port stall, input, 1: hold PC and stack.
REQ-007 Port branch_abs, input, 1: jump to absolute-table entry.
REQ-008 Port branch_rel_z, input, 1: relative branch taken when zero_flag=1.
REQ-009 Port branch_rel_nz, input, 1: relative branch taken when zero_flag=0.
REQ-010 Port call, input, 1: push PC+1, then jump to absolute-table entry.
REQ-011 Port ret, input, 1: pop return address into PC.
REQ-012 Port halt, input, 1: stop fetch.
REQ-013 Port zero_flag, input, 1: registered ALU zero flag.
REQ-014 Port lut_idx, input, LUT_IDX_W: table index for branch, call and table write.
REQ-015 Port lut_wr_en, input, 1: write one table entry.
REQ-016 Port lut_wr_sel, input, 1: 0 selects the relative table, 1 selects the absolute table.
REQ-017 Port lut_wr_data, input, PC_W: entry value; relative entries are two's-complement.
REQ-018 Port pc, output, PC_W: registered instruction address.
REQ-019 Port done, output, 1: registered; high while halted.
REQ-020 Port ras_overflow, output, 1: sticky; a push occurred while the stack was full.
REQ-021 Port ras_underflow, output, 1: sticky; a pop occurred while the stack was empty.

Function
REQ-022 The FSM SHALL have two states, RUN and HALTED; halt in RUN moves it to HALTED; only reset leaves HALTED.
REQ-023 In RUN with stall=0, the next PC SHALL be chosen by priority: halt (hold PC) > ret > call > branch_abs > taken rel_z/rel_nz > PC+1.
REQ-024 Relative branches SHALL compute PC + sign-extended relative entry, modulo 2**PC_W; PC+1 also wraps from all-ones to 0.
REQ-025 Each PC update SHALL appear on pc exactly one cycle after the control is sampled; there is no combinational path from inputs to pc.
REQ-026 stall=1 SHALL freeze pc, the stack and the FSM; table writes still complete.
REQ-027 In HALTED, pc SHALL hold and all branch, call and ret inputs SHALL be ignored.
REQ-028 A table read and a write to the same index in the same cycle SHALL return the old entry; the new value is visible from the next cycle.
REQ-029 call SHALL push PC+1 (wrapped) in the same cycle it loads the target.
REQ-030 call with the stack full SHALL overwrite the oldest entry and set ras_overflow.
REQ-031 ret with the stack empty SHALL load PC+1, leave the stack unchanged and set ras_underflow.
REQ-032 call and ret asserted together SHALL perform ret only.

Reset
REQ-033 reset SHALL take priority over every other input, including stall.
REQ-034 reset SHALL force: pc=0, done=0, FSM=RUN, stack empty, ras_overflow=0, ras_underflow=0, every table entry=0.
REQ-035 reset asserted mid-call or mid-ret SHALL discard that push or pop.

Structure
REQ-036 The definitions package SHALL hold the fetch_state_t enum (RUN, HALTED), the LUT_SEL_REL/LUT_SEL_ABS constants and the default parameter values.
REQ-037 The return-address stack SHALL be a sub-module named fetch_ras, parameterised by PC_W and RAS_DEPTH, with push, pop, top, full, empty, overflow and underflow signals.
REQ-038 Both branch tables SHALL be register arrays inside fetch_unit.

Verification
REQ-039 Reset, then 3 idle cycles -> pc=0,1,2,3; done=0.
REQ-040 Write rel[2]=-4 at pc=10, assert branch_rel_nz with lut_idx=2 and zero_flag=0 -> pc=6; repeat with zero_flag=1 -> pc=7.
REQ-041 Write abs[1]=100, call at pc=20, then ret at pc=100 -> pc=100, then pc=21.
REQ-042 With RAS_DEPTH=4, perform 5 nested calls -> ras_overflow=1; perform 5 rets -> the fifth ret yields PC+1 and ras_underflow=1.
REQ-043 Assert halt at pc=30, then branch_abs -> pc stays 30 and done=1; reset -> pc=0 and done=0.
REQ-044 Write abs[3]=50 and branch_abs on idx 3 in the same cycle -> pc=old entry (0); repeat the branch next cycle -> pc=50.
